div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- Issue-side controller for the multi-cycle divide unit. It sits between decode/issue and the divider.
- Detects DIV/DIVU/REM/REMU in the issue stream and launches them with a one-cycle start pulse.
- Tracks the single outstanding destination register and stalls hazarding instructions.
- Consumes the divider's writeback pulse and produces the register-file write. Handles flush and timeout.

Parameters:
- TIMEOUT_CYCLES, 64: cycles allowed from start pulse to writeback before an error is declared.
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- issue_valid_i  in  1  issue-stage instruction valid
- issue_opcode_i  in  32  instruction word
- issue_pc_i  in  32  instruction PC
- issue_rd_idx_i / issue_ra_idx_i / issue_rb_idx_i  in  5 each  register indices
- issue_ra_operand_i / issue_rb_operand_i  in  32 each  source operand values
- flush_i  in  1  pipeline flush
- issue_accept_o  out  1  issue-stage instruction consumed this cycle
- stall_o  out  1  issue stage must hold
- div_opcode_valid_o  out  1  divider start pulse
- div_opcode_opcode_o, div_opcode_pc_o  out  32 each  registered to divider
- div_opcode_rd_idx_o, div_opcode_ra_idx_o, div_opcode_rb_idx_o  out  5 each  registered to divider
- div_opcode_ra_operand_o, div_opcode_rb_operand_o  out  32 each  registered to divider
- div_writeback_valid_i  in  1  divider result pulse
- div_writeback_value_i  in  32  divider result
- rf_wr_en_o  out  1  register-file write strobe
- rf_wr_idx_o  out  5  register-file write index
- rf_wr_data_o  out  32  register-file write data
- pending_o  out  1  divide outstanding
- pending_rd_o  out  5  destination register of the outstanding divide
- timeout_err_o  out  1  sticky timeout flag
- spurious_err_o  out  1  sticky flag: writeback arrived with nothing pending

Behaviour:
- Reset (rst_ni low, asynchronous): all outputs 0; state IDLE; counter 0; sticky flags cleared. Reset mid-divide abandons the operation. No rf write follows.
- Divide detect: (opcode & INST_x_MASK) == INST_x for DIV, DIVU, REM, REMU.
- States and transitions:
  - IDLE -> ISSUE: on accepting a divide. Capture all issue fields into div_opcode_*_o. Capture rd into pending_rd_o and set pending_o, even when rd = 0.
  - ISSUE, exactly 1 cycle: div_opcode_valid_o = 1. Next state WAIT, or DRAIN if flush_i is high.
  - WAIT:
    - On div_writeback_valid_i: register rf_wr_en_o = (pending_rd != 0), rf_wr_idx_o = pending_rd, rf_wr_data_o = value, all on the next cycle. Go to CLEAR.
    - On flush_i without writeback: go to DRAIN.
    - On flush_i with writeback in the same cycle: discard the result, go to IDLE, clear pending.
  - CLEAR, 1 cycle: rf strobe is high this cycle. pending_o drops at the end of this cycle. Next state IDLE.
  - DRAIN: the divider cannot be cancelled. Wait for div_writeback_valid_i, discard it (no rf write), clear pending, go to IDLE.
- Divider latency is variable: about 34 cycles normally, about 2 cycles when the same operation is repeated with identical operands. Assume no fixed latency.
- Timeout: counter resets at ISSUE and increments each cycle in WAIT/DRAIN. Reaching TIMEOUT_CYCLES sets timeout_err_o (sticky), clears pending, goes to IDLE, and produces no rf write.
- A writeback in IDLE or ISSUE sets spurious_err_o (sticky) and is ignored.
- Hazard and stall (stall_o combinational, issue_accept_o = issue_valid_i & !stall_o & !flush_i):
  - A divide stalls while state != IDLE (single outstanding).
  - A non-divide stalls while pending_o and (ra_idx, rb_idx, or rd_idx == pending_rd != 0).
  - A writeback arriving in the same cycle does not release the stall. Release happens the cycle after CLEAR.
  - flush_i forces issue_accept_o = 0 that cycle. Flush in IDLE has no state effect.
- div_opcode_*_o fields other than valid hold their values until the next issue.

Decomposition:
- Package div_ctrl_pkg:
  - state enum IDLE/ISSUE/WAIT/CLEAR/DRAIN
  - INST_DIV/DIVU/REM/REMU mask and match constants from the shared definitions
  - is_div_op function
- One sub-module, div_scoreboard: pending flag, pending_rd register, RAW/WAW compare producing the hazard signal.

Test Plan:
- DIV rd=5, a=100, b=7 -> one-cycle div_opcode_valid_o. After writeback, rf_wr_en_o=1, idx=5, data=14 one cycle later. pending_o drops the cycle after.
- REM rd=6, a=0xFFFFFFF9, b=2, issued twice back-to-back -> second writeback arrives about 2 cycles after start. Both produce rf data 0xFFFFFFFF. No spurious_err_o.
- DIVU rd=3 then ADD with ra=3 -> stall_o high until the cycle after CLEAR. ADD accepted then. ADD with ra=4 during WAIT is accepted immediately.
- DIV rd=0 -> no rf_wr_en_o. pending cleared. A following DIV is accepted.
- flush_i during WAIT -> DRAIN. Writeback is discarded with no rf write. A new DIV stalls until the writeback, then is accepted.
- Divider stub never responds, TIMEOUT_CYCLES=64 -> timeout_err_o=1 64 cycles after ISSUE; state IDLE. A later stray writeback sets spurious_err_o. rst_ni low clears both flags asynchronously.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared state encoding and divide-instruction decode for the divide issue controller
package div_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CLEAR, DRAIN} state_t;
  localparam logic [31:0] INST_DIV       = 32'h0200_4033;
  localparam logic [31:0] INST_DIV_MASK  = 32'hfe00_707f;
  localparam logic [31:0] INST_DIVU      = 32'h0200_5033;
  localparam logic [31:0] INST_DIVU_MASK = 32'hfe00_707f;
  localparam logic [31:0] INST_REM       = 32'h0200_6033;
  localparam logic [31:0] INST_REM_MASK  = 32'hfe00_707f;
  localparam logic [31:0] INST_REMU      = 32'h0200_7033;
  localparam logic [31:0] INST_REMU_MASK = 32'hfe00_707f;
  function automatic logic is_div_op(input logic [31:0] op);
    return ((op & INST_DIV_MASK) == INST_DIV) || ((op & INST_DIVU_MASK) == INST_DIVU) ||
           ((op & INST_REM_MASK) == INST_REM) || ((op & INST_REMU_MASK) == INST_REMU);
  endfunction
endpackage

// File: rtl/div_issue_ctrl_if.sv
// div_issue_ctrl_if: issue, divider and register-file signals of the divide issue controller
interface div_issue_ctrl_if;
  logic        issue_valid_i;
  logic [31:0] issue_opcode_i;
  logic [31:0] issue_pc_i;
  logic [4:0]  issue_rd_idx_i;
  logic [4:0]  issue_ra_idx_i;
  logic [4:0]  issue_rb_idx_i;
  logic [31:0] issue_ra_operand_i;
  logic [31:0] issue_rb_operand_i;
  logic        flush_i;
  logic        issue_accept_o;
  logic        stall_o;
  logic        div_opcode_valid_o;
  logic [31:0] div_opcode_opcode_o;
  logic [31:0] div_opcode_pc_o;
  logic [4:0]  div_opcode_rd_idx_o;
  logic [4:0]  div_opcode_ra_idx_o;
  logic [4:0]  div_opcode_rb_idx_o;
  logic [31:0] div_opcode_ra_operand_o;
  logic [31:0] div_opcode_rb_operand_o;
  logic        div_writeback_valid_i;
  logic [31:0] div_writeback_value_i;
  logic        rf_wr_en_o;
  logic [4:0]  rf_wr_idx_o;
  logic [31:0] rf_wr_data_o;
  logic        pending_o;
  logic [4:0]  pending_rd_o;
  logic        timeout_err_o;
  logic        spurious_err_o;
  modport master (
    output issue_valid_i, issue_opcode_i, issue_pc_i, issue_rd_idx_i, issue_ra_idx_i, issue_rb_idx_i,
           issue_ra_operand_i, issue_rb_operand_i, flush_i, div_writeback_valid_i, div_writeback_value_i,
    input  issue_accept_o, stall_o, div_opcode_valid_o, div_opcode_opcode_o, div_opcode_pc_o,
           div_opcode_rd_idx_o, div_opcode_ra_idx_o, div_opcode_rb_idx_o, div_opcode_ra_operand_o,
           div_opcode_rb_operand_o, rf_wr_en_o, rf_wr_idx_o, rf_wr_data_o, pending_o, pending_rd_o,
           timeout_err_o, spurious_err_o
  );
  modport slave (
    input  issue_valid_i, issue_opcode_i, issue_pc_i, issue_rd_idx_i, issue_ra_idx_i, issue_rb_idx_i,
           issue_ra_operand_i, issue_rb_operand_i, flush_i, div_writeback_valid_i, div_writeback_value_i,
    output issue_accept_o, stall_o, div_opcode_valid_o, div_opcode_opcode_o, div_opcode_pc_o,
           div_opcode_rd_idx_o, div_opcode_ra_idx_o, div_opcode_rb_idx_o, div_opcode_ra_operand_o,
           div_opcode_rb_operand_o, rf_wr_en_o, rf_wr_idx_o, rf_wr_data_o, pending_o, pending_rd_o,
           timeout_err_o, spurious_err_o
  );
endinterface

// File: rtl/div_scoreboard.sv
// div_scoreboard: single outstanding divide destination and its RAW/WAW hazard compare
module div_scoreboard (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       set,
  input  logic [4:0] set_rd,
  input  logic       clr,
  input  logic [4:0] rd,
  input  logic [4:0] ra,
  input  logic [4:0] rb,
  output logic       pending,
  output logic [4:0] pending_rd,
  output logic       hazard
);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      pending    <= 1'b0;
      pending_rd <= '0;
    end else if (set) begin
      pending    <= 1'b1;
      pending_rd <= set_rd;
    end else if (clr) begin
      pending    <= 1'b0;
    end
  // x0 is never written, so it cannot create a dependency
  assign hazard = pending && pending_rd != '0 && (rd == pending_rd || ra == pending_rd || rb == pending_rd);
endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: launches divides, stalls hazards and turns divider results into register-file writes
module div_issue_ctrl import div_ctrl_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 7
) (
  input logic clk_i,
  input logic rst_ni,
  div_issue_ctrl_if.slave bus
);
  state_t state, next;
  logic [CNT_W-1:0] cnt;
  logic is_div, div_acc, hazard, pending, wb, fl, busy, to_fire, accept_wb, kill_wb;
  logic [4:0] pending_rd;
  assign is_div    = is_div_op(bus.issue_opcode_i);
  assign wb        = bus.div_writeback_valid_i;
  assign fl        = bus.flush_i;
  assign busy      = state == WAIT || state == DRAIN;
  assign to_fire   = busy && !wb && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign accept_wb = state == WAIT && wb && !fl;
  // flushed results (same-cycle flush in WAIT, or anything in DRAIN) are dropped
  assign kill_wb   = busy && wb && !accept_wb;
  assign bus.stall_o            = bus.issue_valid_i && (is_div ? state != IDLE : hazard);
  assign bus.issue_accept_o     = bus.issue_valid_i && !bus.stall_o && !fl;
  assign div_acc                = bus.issue_accept_o && is_div;
  assign bus.div_opcode_valid_o = state == ISSUE;
  assign bus.pending_o          = pending;
  assign bus.pending_rd_o       = pending_rd;
  div_scoreboard u_sb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .set        (div_acc),
    .set_rd     (bus.issue_rd_idx_i),
    .clr        (state == CLEAR || kill_wb || to_fire),
    .rd         (bus.issue_rd_idx_i),
    .ra         (bus.issue_ra_idx_i),
    .rb         (bus.issue_rb_idx_i),
    .pending    (pending),
    .pending_rd (pending_rd),
    .hazard     (hazard)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= next;
  always_comb begin
    next = IDLE;
    next = state == IDLE  ? (div_acc ? ISSUE : IDLE) :
           state == ISSUE ? (fl ? DRAIN : WAIT) :
           busy           ? (accept_wb ? CLEAR : (kill_wb || to_fire) ? IDLE : fl ? DRAIN : state) :
                            IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      bus.div_opcode_opcode_o     <= '0;
      bus.div_opcode_pc_o         <= '0;
      bus.div_opcode_rd_idx_o     <= '0;
      bus.div_opcode_ra_idx_o     <= '0;
      bus.div_opcode_rb_idx_o     <= '0;
      bus.div_opcode_ra_operand_o <= '0;
      bus.div_opcode_rb_operand_o <= '0;
      bus.rf_wr_en_o              <= 1'b0;
      bus.rf_wr_idx_o             <= '0;
      bus.rf_wr_data_o            <= '0;
      bus.timeout_err_o           <= 1'b0;
      bus.spurious_err_o          <= 1'b0;
      cnt                         <= '0;
    end else begin
      if (div_acc) begin
        bus.div_opcode_opcode_o     <= bus.issue_opcode_i;
        bus.div_opcode_pc_o         <= bus.issue_pc_i;
        bus.div_opcode_rd_idx_o     <= bus.issue_rd_idx_i;
        bus.div_opcode_ra_idx_o     <= bus.issue_ra_idx_i;
        bus.div_opcode_rb_idx_o     <= bus.issue_rb_idx_i;
        bus.div_opcode_ra_operand_o <= bus.issue_ra_operand_i;
        bus.div_opcode_rb_operand_o <= bus.issue_rb_operand_i;
      end
      cnt <= state == ISSUE ? '0 : busy ? cnt + 1'b1 : cnt;
      bus.rf_wr_en_o <= accept_wb && pending_rd != '0;
      if (accept_wb) begin
        bus.rf_wr_idx_o  <= pending_rd;
        bus.rf_wr_data_o <= bus.div_writeback_value_i;
      end
      if (to_fire) bus.timeout_err_o <= 1'b1;
      if (wb && (state == IDLE || state == ISSUE)) bus.spurious_err_o <= 1'b1;
    end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed and random stimulus against a transaction-level model of the divide issue controller
module tb_div_issue_ctrl;
  localparam int TO = 64;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  div_issue_ctrl_if bus();
  div_issue_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int checks = 0, failures = 0;
  bit m_busy, m_clear, m_killed, m_terr, m_serr, m_rf_en;
  int m_age;
  logic [4:0] m_prd, m_rf_idx, m_rd, m_ra, m_rb;
  logic [31:0] m_rf_data, m_op, m_pc, m_a, m_b;
  bit c_wb, c_acc, obs_acc, ran, st_never, last_ok;
  logic [31:0] c_wv, st_val, last_a, last_b;
  logic [2:0] last_f3;
  int st_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd, rs1, rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic bit is_div(input logic [31:0] op);
    return op[6:0] == 7'h33 && op[31:25] == 7'h01 && op[14];
  endfunction

  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return f3[1] ? a : 32'hffff_ffff;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hffff_ffff) return f3[1] ? 32'h0 : a;
    case (f3)
      3'd4: return sa / sb;
      3'd5: return a / b;
      3'd6: return sa % sb;
      default: return a % b;
    endcase
  endfunction

  task automatic model_step(input logic [31:0] op, pc, input logic [4:0] rd, ra, rb, input logic [31:0] a, b, input bit fl);
    m_rf_en = 1'b0;
    if (m_clear) begin
      m_busy = 1'b0;
      m_clear = 1'b0;
    end else if (m_busy && m_age == 0) begin
      if (c_wb) m_serr = 1'b1;
      if (fl) m_killed = 1'b1;
      m_age = 1;
    end else if (m_busy) begin
      if (c_wb) begin
        if (m_killed || fl) m_busy = 1'b0;
        else begin
          m_rf_en = m_prd != 0;
          m_rf_idx = m_prd;
          m_rf_data = c_wv;
          m_clear = 1'b1;
        end
      end else if (m_age == TO) begin
        m_terr = 1'b1;
        m_busy = 1'b0;
      end else begin
        if (fl) m_killed = 1'b1;
        m_age++;
      end
    end else begin
      if (c_wb) m_serr = 1'b1;
      if (c_acc && is_div(op)) begin
        m_busy = 1'b1; m_age = 0; m_killed = 1'b0; m_prd = rd;
        m_op = op; m_pc = pc; m_rd = rd; m_ra = ra; m_rb = rb; m_a = a; m_b = b;
      end
    end
  endtask

  task automatic check_regs();
    chk("start", bus.div_opcode_valid_o, m_busy && !m_clear && m_age == 0);
    chk("pending", bus.pending_o, m_busy);
    chk("pending_rd", bus.pending_rd_o, m_prd);
    chk("rf_en", bus.rf_wr_en_o, m_rf_en);
    chk("rf_idx", bus.rf_wr_idx_o, m_rf_idx);
    chk("rf_data", bus.rf_wr_data_o, m_rf_data);
    chk("timeout_err", bus.timeout_err_o, m_terr);
    chk("spurious_err", bus.spurious_err_o, m_serr);
    chk("op", bus.div_opcode_opcode_o, m_op);
    chk("pc", bus.div_opcode_pc_o, m_pc);
    chk("idx", {bus.div_opcode_rd_idx_o, bus.div_opcode_ra_idx_o, bus.div_opcode_rb_idx_o}, {m_rd, m_ra, m_rb});
    chk("opa", bus.div_opcode_ra_operand_o, m_a);
    chk("opb", bus.div_opcode_rb_operand_o, m_b);
  endtask

  task automatic tick(input bit v, input logic [31:0] op, input logic [4:0] rd, ra, rb, input logic [31:0] a, b, input bit fl, input bit stray);
    logic [31:0] pc;
    logic [2:0] f3;
    bit ex_stall, same;
    int lat;
    pc = $urandom & 32'hffff_fffc;
    c_wb = st_cnt == 1 || stray;
    c_wv = st_cnt == 1 ? st_val : $urandom;
    bus.issue_valid_i = v; bus.issue_opcode_i = op; bus.issue_pc_i = pc;
    bus.issue_rd_idx_i = rd; bus.issue_ra_idx_i = ra; bus.issue_rb_idx_i = rb;
    bus.issue_ra_operand_i = a; bus.issue_rb_operand_i = b; bus.flush_i = fl;
    bus.div_writeback_valid_i = c_wb; bus.div_writeback_value_i = c_wv;
    ex_stall = v && (is_div(op) ? m_busy : (m_busy && m_prd != 0 && (ra == m_prd || rb == m_prd || rd == m_prd)));
    c_acc = v && !ex_stall && !fl;
    #1;
    chk("stall", bus.stall_o, ex_stall);
    chk("accept", bus.issue_accept_o, c_acc);
    obs_acc = bus.issue_accept_o;
    lat = -1;
    if (bus.div_opcode_valid_o) begin
      f3 = bus.div_opcode_opcode_o[14:12];
      same = last_ok && f3 == last_f3 && bus.div_opcode_ra_operand_o == last_a && bus.div_opcode_rb_operand_o == last_b;
      last_ok = 1'b1; last_f3 = f3; last_a = bus.div_opcode_ra_operand_o; last_b = bus.div_opcode_rb_operand_o;
      st_val = ref_div(f3, last_a, last_b);
      lat = (st_never || (ran && $urandom_range(24, 0) == 0)) ? 0 : same ? 2 : ran ? int'($urandom_range(40, 1)) : 34;
    end
    @(posedge clk);
    model_step(op, pc, rd, ra, rb, a, b, fl);
    if (lat >= 0) st_cnt = lat;
    else if (st_cnt > 0) st_cnt--;
    #1;
    check_regs();
  endtask

  task automatic idle();
    tick(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    for (int i = 0; i < 100 && m_busy; i++) idle();
  endtask

  task automatic do_reset();
    bus.issue_valid_i = 1'b0; bus.issue_opcode_i = '0; bus.issue_pc_i = '0;
    bus.issue_rd_idx_i = '0; bus.issue_ra_idx_i = '0; bus.issue_rb_idx_i = '0;
    bus.issue_ra_operand_i = '0; bus.issue_rb_operand_i = '0; bus.flush_i = 1'b0;
    bus.div_writeback_valid_i = 1'b0; bus.div_writeback_value_i = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_start", bus.div_opcode_valid_o, 0);
    chk("rst_pending", {bus.pending_o, bus.pending_rd_o}, 0);
    chk("rst_rf", {bus.rf_wr_en_o, bus.rf_wr_idx_o}, 0);
    chk("rst_rf_data", bus.rf_wr_data_o, 0);
    chk("rst_errs", {bus.timeout_err_o, bus.spurious_err_o}, 0);
    chk("rst_op", bus.div_opcode_opcode_o | bus.div_opcode_ra_operand_o | bus.div_opcode_rb_operand_o, 0);
    chk("rst_stall", {bus.stall_o, bus.issue_accept_o}, 0);
    m_busy = 0; m_clear = 0; m_killed = 0; m_terr = 0; m_serr = 0; m_rf_en = 0; m_age = 0;
    m_prd = 0; m_rf_idx = 0; m_rd = 0; m_ra = 0; m_rb = 0;
    m_rf_data = 0; m_op = 0; m_pc = 0; m_a = 0; m_b = 0;
    st_cnt = 0; last_ok = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bit saw;
    logic [4:0] rd, ra, rb;
    logic [31:0] op, a, b;
    logic [31:0] av [4];
    logic [31:0] bv [4];
    av = '{32'd100, 32'hffff_fff9, 32'h8000_0000, 32'd0};
    bv = '{32'd7, 32'd2, 32'd0, 32'hffff_ffff};
    ran = 0; st_never = 0;
    #1 do_reset();
    // DIV 100/7 into x5
    tick(1, rtype(7'd1, 3'd4, 5'd5, 5'd1, 5'd2), 5'd5, 5'd1, 5'd2, 32'd100, 32'd7, 0, 0);
    chk("t1_start", bus.div_opcode_valid_o, 1);
    for (int i = 0; i < 60 && !bus.rf_wr_en_o; i++) idle();
    chk("t1_rf", {bus.rf_wr_en_o, bus.rf_wr_idx_o}, {1'b1, 5'd5});
    chk("t1_data", bus.rf_wr_data_o, 14);
    idle();
    chk("t1_pend_drop", bus.pending_o, 0);
    // REM repeated with identical operands
    op = rtype(7'd1, 3'd6, 5'd6, 5'd1, 5'd2);
    tick(1, op, 5'd6, 5'd1, 5'd2, 32'hffff_fff9, 32'd2, 0, 0);
    for (int i = 0; i < 100; i++) begin
      tick(1, op, 5'd6, 5'd1, 5'd2, 32'hffff_fff9, 32'd2, 0, 0);
      if (obs_acc) break;
    end
    chk("t2_acc", obs_acc, 1);
    n = 0;
    while (!bus.rf_wr_en_o && n < 20) begin idle(); n++; end
    chk("t2_lat", n, 3);
    chk("t2_data", bus.rf_wr_data_o, 32'hffff_ffff);
    settle();
    chk("t2_spur", bus.spurious_err_o, 0);
    // DIVU into x3, independent and dependent ADDs
    tick(1, rtype(7'd1, 3'd5, 5'd3, 5'd1, 5'd2), 5'd3, 5'd1, 5'd2, 32'd50, 32'd5, 0, 0);
    idle();
    tick(1, rtype(7'd0, 3'd0, 5'd9, 5'd4, 5'd1), 5'd9, 5'd4, 5'd1, 32'd1, 32'd2, 0, 0);
    chk("t3_indep", obs_acc, 1);
    saw = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1, rtype(7'd0, 3'd0, 5'd9, 5'd3, 5'd1), 5'd9, 5'd3, 5'd1, 32'd1, 32'd2, 0, 0);
      if (obs_acc) break;
      saw |= bus.rf_wr_en_o;
    end
    chk("t3_dep_acc", obs_acc, 1);
    chk("t3_after_clear", saw, 1);
    // DIV into x0: no write, but pending still clears
    tick(1, rtype(7'd1, 3'd4, 5'd0, 5'd1, 5'd2), 5'd0, 5'd1, 5'd2, 32'd9, 32'd3, 0, 0);
    saw = 0;
    for (int i = 0; i < 100 && bus.pending_o; i++) begin idle(); saw |= bus.rf_wr_en_o; end
    chk("t4_no_rf", saw, 0);
    chk("t4_clear", bus.pending_o, 0);
    tick(1, rtype(7'd1, 3'd4, 5'd7, 5'd1, 5'd2), 5'd7, 5'd1, 5'd2, 32'd9, 32'd4, 0, 0);
    chk("t4_next", obs_acc, 1);
    settle();
    // flush during WAIT drains the result
    tick(1, rtype(7'd1, 3'd4, 5'd8, 5'd1, 5'd2), 5'd8, 5'd1, 5'd2, 32'd1000, 32'd10, 0, 0);
    repeat (3) idle();
    tick(0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1, 0);
    chk("t5_pend", bus.pending_o, 1);
    saw = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1, rtype(7'd1, 3'd4, 5'd9, 5'd1, 5'd2), 5'd9, 5'd1, 5'd2, 32'd5, 32'd5, 0, 0);
      if (obs_acc) break;
      saw |= bus.rf_wr_en_o;
    end
    chk("t5_no_rf", saw, 0);
    chk("t5_acc", obs_acc, 1);
    settle();
    // divider never answers
    st_never = 1;
    tick(1, rtype(7'd1, 3'd4, 5'd10, 5'd1, 5'd2), 5'd10, 5'd1, 5'd2, 32'd77, 32'd7, 0, 0);
    n = 0;
    while (!bus.timeout_err_o && n < 200) begin idle(); n++; end
    chk("t6_cycles", n, TO + 1);
    chk("t6_pend", bus.pending_o, 0);
    st_never = 0;
    tick(0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 0, 1);
    chk("t6_spur", bus.spurious_err_o, 1);
    do_reset();
    // random traffic
    ran = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      rd = 5'($urandom_range(7, 0)); ra = 5'($urandom_range(7, 0)); rb = 5'($urandom_range(7, 0));
      n = int'($urandom_range(9, 0));
      op = n < 4 ? rtype(7'd1, 3'(4 + $urandom_range(3, 0)), rd, ra, rb) :
           n < 8 ? rtype(7'($urandom_range(1, 0)), 3'($urandom_range(3, 0)), rd, ra, rb) : $urandom;
      a = av[$urandom_range(3, 0)];
      b = bv[$urandom_range(3, 0)];
      tick($urandom_range(2, 0) != 0, op, rd, ra, rb, a, b, $urandom_range(15, 0) == 0, $urandom_range(399, 0) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
